// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: operand
// forwarding, load-use / PC-write / branch stalls and flushes, a freeze FSM
// for multi-cycle data-memory accesses, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemAccessM,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemBusy,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam bit         HAS_WAIT  = (MEM_WAIT != 0);
  localparam logic [3:0] WAIT_INIT = 4'((MEM_WAIT != 0) ? MEM_WAIT - 1 : 0);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             busy;
  logic             ld_stall;
  logic             pc_pend;

  // Memory-wait FSM: next state, wait counter and busy flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (MemAccessM && HAS_WAIT) begin
          busy    = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          busy  = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Forwarding selects and stall/flush outputs; reset forces a flushed idle pipe.
  always_comb begin
    ld_stall  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    pc_pend   = PCSrcD || PCSrcE || PCSrcM;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemBusy   = 1'b0;
    if (!RST) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
      else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
      if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
      else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
      if (busy) begin
        // Freeze everything; pending branch/load-use flushes wait for release.
        MemBusy = 1'b1;
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        StallM  = 1'b1;
        FlushW  = 1'b1;
      end else begin
        StallF = ld_stall || pc_pend;
        StallD = ld_stall;
        FlushD = pc_pend || PCSrcW || BranchTakenE;
        FlushE = ld_stall || BranchTakenE;
      end
    end
  end

  // Saturating count of cycles with the fetch stage stalled.
  always_comb begin
    stall_count_d = stall_count_q;
    if (StallF && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (MEM_WAIT=2/CNT_W=16 and
// MEM_WAIT=0/CNT_W=4) share one stimulus; an occupancy-age model is compared
// every cycle, and directed vectors carry hand-computed literal expectations.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, MemAccessM;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, mb0;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, mb1;
  logic [15:0] cnt_dut0;
  logic [3:0]  cnt_dut1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int age0 = -1, age1 = -1;
  int cm0 = 0, cm1 = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REG_AW(4), .MEM_WAIT(2), .CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .ForwardAE(fa0), .ForwardBE(fb0),
    .StallF(sf0), .StallD(sd0), .StallE(se0), .StallM(sm0), .FlushD(fd0),
    .FlushE(fe0), .FlushW(fw0), .MemBusy(mb0), .StallCount(cnt_dut0));

  hazard_ctrl #(.REG_AW(4), .MEM_WAIT(0), .CNT_W(4)) u_dut0 (
    .CLK(CLK), .RST(RST), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MemAccessM(MemAccessM),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1), .FlushD(fd1),
    .FlushE(fe1), .FlushW(fw1), .MemBusy(mb1), .StallCount(cnt_dut1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: age = cycles the current access has spent in Memory (-1 = none).
  // An access occupies Memory for mw+1 cycles and is busy for the first mw.
  // ctl = {MemBusy, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic void model(input int mw, input int age,
                                output logic [1:0] fa, output logic [1:0] fb,
                                output logic [7:0] ctl, output int nage);
    int ea;
    bit bsy, ld, pc;
    ea   = (age < 0 && MemAccessM && mw > 0) ? 0 : age;
    bsy  = (ea >= 0) && (ea < mw);
    nage = (ea < 0 || ea == mw) ? -1 : ea + 1;
    ld   = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    pc   = PCSrcD || PCSrcE || PCSrcM;
    fa   = (RegWriteM && RA1E == WA3M) ? 2'd2 : (RegWriteW && RA1E == WA3W) ? 2'd1 : 2'd0;
    fb   = (RegWriteM && RA2E == WA3M) ? 2'd2 : (RegWriteW && RA2E == WA3W) ? 2'd1 : 2'd0;
    if (!RST) begin
      fa = 2'd0; fb = 2'd0; ctl = 8'b0000_0111; nage = -1;
    end else if (bsy) begin
      ctl = 8'b1111_1001;
    end else begin
      ctl = {1'b0, ld | pc, ld, 1'b0, 1'b0, pc | PCSrcW | BranchTakenE, ld | BranchTakenE, 1'b0};
    end
  endfunction

  // Advance the model on each clock edge.
  always @(posedge CLK) begin
    logic [1:0] a, b;
    logic [7:0] c;
    int n;
    model(2, age0, a, b, c, n);
    if (!RST) begin age0 <= -1; cm0 <= 0; end
    else begin
      age0 <= n;
      if (c[6] && cm0 < 65535) cm0 <= cm0 + 1;
    end
    model(0, age1, a, b, c, n);
    if (!RST) begin age1 <= -1; cm1 <= 0; end
    else begin
      age1 <= n;
      if (c[6] && cm1 < 15) cm1 <= cm1 + 1;
    end
  end

  // Compare both instances against the model mid-cycle.
  always @(negedge CLK) begin
    logic [1:0] a, b;
    logic [7:0] c;
    int n;
    if (chk_en) begin
      model(2, age0, a, b, c, n);
      chk("w2.ForwardAE", 32'(fa0), 32'(a));
      chk("w2.ForwardBE", 32'(fb0), 32'(b));
      chk("w2.ctl", 32'({mb0, sf0, sd0, se0, sm0, fd0, fe0, fw0}), 32'(c));
      chk("w2.StallCount", 32'(cnt_dut0), 32'(cm0));
      model(0, age1, a, b, c, n);
      chk("w0.ForwardAE", 32'(fa1), 32'(a));
      chk("w0.ForwardBE", 32'(fb1), 32'(b));
      chk("w0.ctl", 32'({mb1, sf1, sd1, se1, sm1, fd1, fe1, fw1}), 32'(c));
      chk("w0.StallCount", 32'(cnt_dut1), 32'(cm1));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemtoRegE, MemAccessM} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [5:0] b2b;
    b2b = 6'b011011;
    clear_in();
    RST = 1'b0;
    // Reset forces outputs even with forwarding and PC-write inputs active.
    RegWriteM = 1'b1; RA1E = 4'd3; WA3M = 4'd3; PCSrcD = 1'b1;
    #2;
    chk("rst.ForwardAE", 32'(fa0), 32'd0);
    chk("rst.StallF", 32'(sf0), 32'd0);
    chk("rst.flushes", 32'({fd0, fe0, fw0}), 32'b111);
    chk("rst.MemBusy", 32'(mb0), 32'd0);
    step();
    chk_en = 1'b1;
    step();
    RST = 1'b1;
    clear_in();
    #2;
    chk("rst.StallCount", 32'(cnt_dut0), 32'd0);

    // Forwarding priority.
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1; RA2E = 4'd5;
    #2;
    chk("fwd.mem", 32'(fa0), 32'd2);
    chk("fwd.none", 32'(fb0), 32'd0);
    step();
    RegWriteM = 1'b0;
    #2;
    chk("fwd.wb", 32'(fa0), 32'd1);
    step();
    clear_in();

    // Load-use hazard.
    MemtoRegE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd7;
    #2;
    chk("ld.stalls", 32'({sf0, sd0, fe0}), 32'b111);
    chk("ld.cnt_before", 32'(cnt_dut0), 32'd0);
    step();
    clear_in();
    #2;
    chk("ld.cnt_after", 32'(cnt_dut0), 32'd1);

    // Memory wait with a taken branch held pending underneath.
    MemAccessM = 1'b1; BranchTakenE = 1'b1;
    #2;
    chk("mw.c0", 32'({mb0, sf0, sd0, se0, sm0, fd0, fe0, fw0}), 32'b1111_1001);
    chk("mw0.nobusy", 32'({mb1, fd1, fe1}), 32'b011);
    step();
    #2;
    chk("mw.c1", 32'({mb0, sm0, fd0, fe0, fw0}), 32'b11001);
    step();
    #2;
    chk("mw.release", 32'({mb0, sm0, fd0, fe0, fw0}), 32'b00110);
    step();
    clear_in();

    // Back-to-back accesses retrigger with no gap cycle.
    MemAccessM = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("b2b.MemBusy", 32'(mb0), 32'(b2b[i]));
      step();
    end
    clear_in();

    // PC-writing instruction walking D -> E -> M -> W.
    PCSrcD = 1'b1;
    #2; chk("pc.D", 32'({sf0, fd0}), 32'b11);
    step(); PCSrcD = 1'b0; PCSrcE = 1'b1;
    #2; chk("pc.E", 32'({sf0, fd0}), 32'b11);
    step(); PCSrcE = 1'b0; PCSrcM = 1'b1;
    #2; chk("pc.M", 32'({sf0, fd0}), 32'b11);
    step(); PCSrcM = 1'b0; PCSrcW = 1'b1;
    #2; chk("pc.W", 32'({sf0, fd0}), 32'b01);
    step();
    clear_in();

    // Reset in WAIT with cnt=1 aborts the wait.
    MemAccessM = 1'b1;
    #2; chk("rw.busy", 32'(mb0), 32'd1);
    step();
    RST = 1'b0;
    #2; chk("rw.forced", 32'({mb0, fd0}), 32'b01);
    step();
    RST = 1'b1; MemAccessM = 1'b0;
    #2;
    chk("rw.run", 32'({mb0, sf0}), 32'b00);
    chk("rw.cnt", 32'(cnt_dut0), 32'd0);
    step();

    // 20 stall cycles: CNT_W=4 saturates at 15, CNT_W=16 reaches 20.
    PCSrcD = 1'b1;
    for (int i = 0; i < 20; i++) step();
    PCSrcD = 1'b0;
    #2;
    chk("sat.w4", 32'(cnt_dut1), 32'd15);
    chk("sat.w16", 32'(cnt_dut0), 32'd20);
    step();
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
